// File: rtl/seq_stream_checker.sv
// Read-side sequence checker: locks onto an incrementing counter stream and reports lock, mismatches and counters.
// Optional build macro SEQCHK_SKIP_ZERO_EN makes IDLE ignore zero samples while waiting for the first seed.
module seq_stream_checker #(
  parameter int DW       = 32,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 2
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN,
  input  logic [DW-1:0] DIN,
  input  logic          CLR,
  output logic          LOCKED,
  output logic          ERR_PULSE,
  output logic [15:0]   ERR_CNT,
  output logic [31:0]   OK_CNT,
  output logic [DW-1:0] EXP
);

  localparam int RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int MISS_W = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t              state_q,     state_d;
  logic [DW-1:0]       exp_q,       exp_d;
  logic [RUN_W-1:0]    run_q,       run_d;
  logic [MISS_W-1:0]   miss_q,      miss_d;
  logic [15:0]         err_cnt_q,   err_cnt_d;
  logic [31:0]         ok_cnt_q,    ok_cnt_d;
  logic                err_pulse_q, err_pulse_d;
  logic                locked_q,    locked_d;

  logic                hit;
  logic                run_last;
  logic                miss_last;
  logic                seed_ok;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Successor in the counter sequence; wraps naturally mod 2^DW.
  function automatic logic [DW-1:0] seq_next(input logic [DW-1:0] v);
    return v + {{(DW-1){1'b0}}, 1'b1};
  endfunction

  assign hit       = (DIN == exp_q);
  assign run_last  = (run_q == RUN_W'(LOCK_CNT - 1));
  assign miss_last = (miss_q == MISS_W'(LOSS_CNT - 1));

`ifdef SEQCHK_SKIP_ZERO_EN
  // Zero is FIFO read data before the threshold is reached; it must not seed the sequence.
  assign seed_ok = (DIN != '0);
`else
  assign seed_ok = 1'b1;
`endif

  always_comb begin
    state_d     = state_q;
    exp_d       = exp_q;
    run_d       = run_q;
    miss_d      = miss_q;
    err_cnt_d   = err_cnt_q;
    ok_cnt_d    = ok_cnt_q;
    err_pulse_d = 1'b0;

    if (EN) begin
      unique case (state_q)
        ST_IDLE: begin
          if (seed_ok) begin
            exp_d   = seq_next(DIN);
            run_d   = RUN_W'(1);
            state_d = ST_SYNC;
          end
        end

        ST_SYNC: begin
          exp_d = seq_next(DIN);
          if (hit) begin
            run_d = run_q + RUN_W'(1);
            if (run_last) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end
          end else begin
            run_d = RUN_W'(1);
          end
        end

        ST_LOCKED: begin
          if (hit) begin
            ok_cnt_d = ok_cnt_q + 32'd1;
            exp_d    = seq_next(exp_q);
            miss_d   = '0;
          end else begin
            err_pulse_d = 1'b1;
            err_cnt_d   = sat_inc16(err_cnt_q);
            miss_d      = miss_q + MISS_W'(1);
            if (miss_last) begin
              // Too many consecutive misses: resynchronise on the current sample.
              state_d = ST_SYNC;
              exp_d   = seq_next(DIN);
              run_d   = RUN_W'(1);
            end else begin
              // Isolated miss: assume a dropped/corrupted word and keep tracking the gap.
              exp_d = seq_next(exp_q);
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end

    if (CLR) begin
      err_cnt_d = '0;
      ok_cnt_d  = '0;
    end

    locked_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      exp_q       <= '0;
      run_q       <= '0;
      miss_q      <= '0;
      err_cnt_q   <= '0;
      ok_cnt_q    <= '0;
      err_pulse_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_q       <= exp_d;
      run_q       <= run_d;
      miss_q      <= miss_d;
      err_cnt_q   <= err_cnt_d;
      ok_cnt_q    <= ok_cnt_d;
      err_pulse_q <= err_pulse_d;
      locked_q    <= locked_d;
    end
  end

  assign LOCKED    = locked_q;
  assign ERR_PULSE = err_pulse_q;
  assign ERR_CNT   = err_cnt_q;
  assign OK_CNT    = ok_cnt_q;
  assign EXP       = exp_q;

endmodule

// File: tb/tb_seq_stream_checker.sv
// Bench for seq_stream_checker: a 32-bit and an 8-bit instance driven together, each checked
// every cycle against a rule-level model, plus literal expectations for the directed scenarios.
module tb_seq_stream_checker;

  localparam int LOCK = 4;
  localparam int LOSS = 2;

`ifdef SEQCHK_SKIP_ZERO_EN
  localparam bit SKIPZ = 1'b1;
`else
  localparam bit SKIPZ = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST, EN, CLR;
  logic [31:0] DIN;

  logic        l32, p32, l8, p8;
  logic [15:0] e32, e8;
  logic [31:0] ok32, ok8, x32;
  logic [7:0]  x8;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  seq_stream_checker #(.DW(32), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut32 (
    .CLK(CLK), .RST(RST), .EN(EN), .DIN(DIN), .CLR(CLR),
    .LOCKED(l32), .ERR_PULSE(p32), .ERR_CNT(e32), .OK_CNT(ok32), .EXP(x32)
  );

  seq_stream_checker #(.DW(8), .LOCK_CNT(LOCK), .LOSS_CNT(LOSS)) dut8 (
    .CLK(CLK), .RST(RST), .EN(EN), .DIN(DIN[7:0]), .CLR(CLR),
    .LOCKED(l8), .ERR_PULSE(p8), .ERR_CNT(e8), .OK_CNT(ok8), .EXP(x8)
  );

  // Model state: st 0=idle 1=sync 2=locked
  typedef struct packed {
    logic [1:0]  st;
    logic [31:0] exp;
    logic [7:0]  run;
    logic [7:0]  miss;
    logic [15:0] errc;
    logic [31:0] okc;
    logic        pulse;
  } mdl_t;

  mdl_t m32, m8;

  function automatic mdl_t step(input mdl_t mi, input logic en, input logic [31:0] din_raw,
                                input logic clr, input logic rst, input logic [31:0] mask);
    mdl_t m = mi;
    logic [31:0] din = din_raw & mask;
    if (rst) return '0;
    m.pulse = 1'b0;
    if (en) begin
      if (m.st == 2'd0) begin
        if (!(SKIPZ && din == 32'd0)) begin
          m.exp = (din + 32'd1) & mask; m.run = 8'd1; m.st = 2'd1;
        end
      end else if (m.st == 2'd1) begin
        if (din == m.exp) begin
          m.run = m.run + 8'd1;
          if (int'(m.run) == LOCK) begin m.st = 2'd2; m.miss = 8'd0; end
        end else begin
          m.run = 8'd1;
        end
        m.exp = (din + 32'd1) & mask;
      end else begin
        if (din == m.exp) begin
          m.okc = m.okc + 32'd1; m.miss = 8'd0;
          m.exp = (m.exp + 32'd1) & mask;
        end else begin
          m.pulse = 1'b1;
          if (m.errc != 16'hFFFF) m.errc = m.errc + 16'd1;
          m.miss = m.miss + 8'd1;
          m.exp  = (m.exp + 32'd1) & mask;
          if (int'(m.miss) == LOSS) begin
            m.st = 2'd1; m.exp = (din + 32'd1) & mask; m.run = 8'd1;
          end
        end
      end
    end
    if (clr) begin m.errc = 16'd0; m.okc = 32'd0; end
    return m;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic compare_all();
    chk("locked32", 64'(l32), 64'(m32.st == 2'd2));
    chk("pulse32",  64'(p32), 64'(m32.pulse));
    chk("errcnt32", 64'(e32), 64'(m32.errc));
    chk("okcnt32",  64'(ok32), 64'(m32.okc));
    chk("exp32",    64'(x32), 64'(m32.exp));
    chk("locked8",  64'(l8), 64'(m8.st == 2'd2));
    chk("pulse8",   64'(p8), 64'(m8.pulse));
    chk("errcnt8",  64'(e8), 64'(m8.errc));
    chk("okcnt8",   64'(ok8), 64'(m8.okc));
    chk("exp8",     64'(x8), 64'(m8.exp[7:0]));
  endtask

  task automatic cyc(input logic en, input logic [31:0] d, input logic clr, input logic rst);
    EN = en; DIN = d; CLR = clr; RST = rst;
    @(posedge CLK);
    m32 = step(m32, en, d, clr, rst, 32'hFFFF_FFFF);
    m8  = step(m8,  en, d, clr, rst, 32'h0000_00FF);
    @(negedge CLK);
    compare_all();
  endtask

  task automatic do_reset();
    cyc(1'b0, 32'd0, 1'b0, 1'b1);
  endtask

  initial begin
    logic [31:0] d;
    logic        en, clr, rst;
    int          r;
    m32 = '0; m8 = '0;
    EN = 1'b0; DIN = '0; CLR = 1'b0; RST = 1'b1;
    @(negedge CLK);
    do_reset();
    do_reset();
    chk("rst_locked", 64'(l32), 64'd0);
    chk("rst_pulse",  64'(p32), 64'd0);
    chk("rst_err",    64'(e32), 64'd0);
    chk("rst_ok",     64'(ok32), 64'd0);
    chk("rst_exp",    64'(x32), 64'd0);

    // Basic lock on 100,101,...
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, 32'd100 + 32'(i), 1'b0, 1'b0);
      if (i == 2) chk("lock_not_yet", 64'(l32), 64'd0);
      if (i == 3) chk("lock_at_4th", 64'(l32), 64'd1);
    end
    chk("basic_ok",  64'(ok32), 64'd10);
    chk("basic_err", 64'(e32), 64'd0);
    chk("basic_exp", 64'(x32), 64'd114);

    // Single bad sample while locked
    do_reset();
    for (int i = 196; i < 200; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'd200, 1'b0, 1'b0);
    cyc(1'b1, 32'd201, 1'b0, 1'b0);
    cyc(1'b1, 32'd999, 1'b0, 1'b0);
    chk("single_pulse", 64'(p32), 64'd1);
    cyc(1'b1, 32'd203, 1'b0, 1'b0);
    chk("single_pulse_end", 64'(p32), 64'd0);
    cyc(1'b1, 32'd204, 1'b0, 1'b0);
    chk("single_err",    64'(e32), 64'd1);
    chk("single_locked", 64'(l32), 64'd1);
    chk("single_ok",     64'(ok32), 64'd4);

    // Two consecutive misses drop lock, then relock
    do_reset();
    for (int i = 46; i < 52; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'd7, 1'b0, 1'b0);
    chk("loss_pulse1",  64'(p32), 64'd1);
    chk("loss_still",   64'(l32), 64'd1);
    cyc(1'b1, 32'd8, 1'b0, 1'b0);
    chk("loss_pulse2",  64'(p32), 64'd1);
    chk("loss_dropped", 64'(l32), 64'd0);
    chk("loss_err",     64'(e32), 64'd2);
    for (int i = 9; i < 13; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    chk("loss_relock",  64'(l32), 64'd1);

    // Wrap: 8-bit and 32-bit
    do_reset();
    cyc(1'b1, 32'd253, 1'b0, 1'b0);
    cyc(1'b1, 32'd254, 1'b0, 1'b0);
    cyc(1'b1, 32'd255, 1'b0, 1'b0);
    cyc(1'b1, 32'd0,   1'b0, 1'b0);
    cyc(1'b1, 32'd1,   1'b0, 1'b0);
    chk("wrap8_locked", 64'(l8), 64'd1);
    chk("wrap8_err",    64'(e8), 64'd0);
    chk("wrap8_exp",    64'(x8), 64'd2);
    do_reset();
    cyc(1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);
    cyc(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    cyc(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    cyc(1'b1, 32'd0,         1'b0, 1'b0);
    cyc(1'b1, 32'd1,         1'b0, 1'b0);
    chk("wrap32_locked", 64'(l32), 64'd1);
    chk("wrap32_exp",    64'(x32), 64'd2);
    chk("wrap32_ok",     64'(ok32), 64'd1);

    // Leading zeros then 5..8
    do_reset();
    cyc(1'b1, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, 32'd5, 1'b0, 1'b0);
    cyc(1'b1, 32'd6, 1'b0, 1'b0);
    cyc(1'b1, 32'd7, 1'b0, 1'b0);
    chk("zero_not_locked", 64'(l32), 64'd0);
    cyc(1'b1, 32'd8, 1'b0, 1'b0);
    chk("zero_locked", 64'(l32), 64'd1);
    chk("zero_err",    64'(e32), 64'd0);

    // CLR coincident with a locked mismatch, then reset mid-stream
    do_reset();
    for (int i = 10; i < 15; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'd99, 1'b1, 1'b0);
    chk("clr_pulse", 64'(p32), 64'd1);
    chk("clr_err",   64'(e32), 64'd0);
    chk("clr_ok",    64'(ok32), 64'd0);
    chk("clr_exp",   64'(x32), 64'd16);
    cyc(1'b1, 32'd16, 1'b0, 1'b0);
    cyc(1'b1, 32'd500, 1'b0, 1'b1);
    chk("mid_rst_locked", 64'(l32), 64'd0);
    chk("mid_rst_exp",    64'(x32), 64'd0);
    chk("mid_rst_pulse",  64'(p32), 64'd0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      en  = ($urandom_range(0, 9) < 8);
      r   = int'($urandom_range(0, 99));
      if (r < 80)      d = m32.exp;
      else if (r < 90) d = $urandom;
      else if (r < 95) d = 32'd0;
      else             d = m32.exp + 32'd1;
      clr = en && ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 499) == 0);
      cyc(en, d, clr, rst);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
